keccak_sram_sequencer: RTL and testbench

Sequencer and arbiter in front of the Keccak state SRAM. It shares the single SRAM port between the system bus and the permutation flow. On a start command it reads the 1600-bit state (50 words) from SRAM into a local register and launches the Keccak core. When the core finishes, it writes the result back to the same words. Bus accesses are served only while the sequencer is idle.

---
 rtl/keccak_sram_sequencer_if.sv | 17 +
 rtl/keccak_sram_sequencer.sv | 177 +++++++++++++++++
 tb/tb_keccak_sram_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/keccak_sram_sequencer_if.sv
// System-bus side of the Keccak state SRAM sequencer: request/grant plus
// one-cycle-latency read return.
interface keccak_sram_sequencer_if #(
  parameter int AddrWidth = 6
) ();
  logic                 req;
  logic                 we;
  logic [AddrWidth-1:0] addr;
  logic [31:0]          wdata;
  logic [3:0]           be;
  logic                 gnt;
  logic                 rvalid;
  logic [31:0]          rdata;

  modport master (output req, we, addr, wdata, be, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/keccak_sram_sequencer.sv
// Shares the single state-SRAM port between the system bus and the Keccak
// permutation flow: load 50 words, run the core, write the result back.
module keccak_sram_sequencer #(
  parameter int NumWords  = 64,
  parameter int AddrWidth = $clog2(NumWords),
  parameter int BaseAddr  = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  keccak_sram_sequencer_if.slave bus,
  output logic                   sram_req_o,
  output logic                   sram_we_o,
  output logic [AddrWidth-1:0]   sram_addr_o,
  output logic [31:0]            sram_wdata_o,
  output logic [3:0]             sram_be_o,
  input  logic [31:0]            sram_rdata_i,
  output logic                   keccak_start_o,
  output logic [1599:0]          keccak_din_o,
  input  logic [1599:0]          keccak_dout_i,
  input  logic                   keccak_done_i
);

  localparam int          NumStateWords = 50;
  localparam logic [5:0]  LastWord      = 6'd49;

  if (BaseAddr + NumStateWords > NumWords) begin : g_base_check
    $error("BaseAddr + 50 exceeds NumWords");
  end

  typedef enum logic [2:0] {
    IDLE, LOAD, LOAD_LAST, START, RUN, STORE, DONE
  } state_e;

  state_e                state_r, state_s;
  logic [5:0]            cnt_r, cnt_s;
  logic [49:0][31:0]     din_r;
  logic                  rvalid_r;
  logic [5:0]            cap_idx_s;
  logic [AddrWidth-1:0]  word_addr_s;

  assign cap_idx_s   = cnt_r - 6'd1;
  assign word_addr_s = AddrWidth'(BaseAddr) + AddrWidth'(cnt_r);

  // Next-state and word counter
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          state_s = LOAD;
          cnt_s   = 6'd0;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        // cnt runs one past the last word so LOAD_LAST captures at cnt-1 too
        cnt_s = cnt_r + 6'd1;
        if (cnt_r == LastWord) begin
          state_s = LOAD_LAST;
        end else begin
          state_s = LOAD;
        end
      end
      LOAD_LAST: begin
        state_s = START;
        cnt_s   = 6'd0;
      end
      START: state_s = RUN;
      RUN: begin
        if (keccak_done_i) begin
          state_s = STORE;
          cnt_s   = 6'd0;
        end else begin
          state_s = RUN;
        end
      end
      STORE: begin
        if (cnt_r == LastWord) begin
          state_s = DONE;
          cnt_s   = 6'd0;
        end else begin
          cnt_s   = cnt_r + 6'd1;
        end
      end
      DONE: state_s = IDLE;
      default: begin
        state_s = IDLE;
        cnt_s   = 6'd0;
      end
    endcase
  end

  // FSM state and counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
      cnt_r   <= 6'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // State register: frozen during RUN so the core sees a stable input
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      din_r <= '0;
    end else if ((state_r == LOAD && cnt_r != 6'd0) || state_r == LOAD_LAST) begin
      din_r[cap_idx_s] <= sram_rdata_i;
    end else if (state_r == RUN && keccak_done_i) begin
      din_r <= keccak_dout_i;
    end else begin
      din_r <= din_r;
    end
  end

  // Read-return flag, only for bus reads granted in IDLE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_r <= 1'b0;
    end else begin
      rvalid_r <= (state_r == IDLE) && bus.req && !bus.we;
    end
  end

  // SRAM port mux and bus grant
  always_comb begin
    bus.gnt      = 1'b0;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = 32'h0;
    sram_be_o    = 4'h0;
    case (state_r)
      IDLE: begin
        bus.gnt    = bus.req;
        sram_req_o = bus.req;
        if (bus.req) begin
          sram_we_o    = bus.we;
          sram_addr_o  = bus.addr;
          sram_wdata_o = bus.wdata;
          sram_be_o    = bus.be;
        end else begin
          sram_we_o    = 1'b0;
        end
      end
      LOAD: begin
        sram_req_o  = 1'b1;
        sram_addr_o = word_addr_s;
        sram_be_o   = 4'hF;
      end
      STORE: begin
        sram_req_o   = 1'b1;
        sram_we_o    = 1'b1;
        sram_addr_o  = word_addr_s;
        sram_wdata_o = din_r[cnt_r];
        sram_be_o    = 4'hF;
      end
      default: begin
        sram_req_o = 1'b0;
      end
    endcase
  end

  assign bus.rvalid     = rvalid_r;
  assign bus.rdata      = rvalid_r ? sram_rdata_i : 32'h0;
  assign busy_o         = (state_r != IDLE);
  assign done_o         = (state_r == DONE);
  assign keccak_start_o = (state_r == START);
  assign keccak_din_o   = din_r;

endmodule

// File: tb/tb_keccak_sram_sequencer.sv
// Self-checking bench: behavioural SRAM, reference memory image and a
// complement-the-state core model drive randomized and directed flows.
module tb_keccak_sram_sequencer;
  localparam int NW   = 64;
  localparam int AW   = 6;
  localparam int BASE = 10;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            busy, done;
  logic            sram_req, sram_we;
  logic [AW-1:0]   sram_addr;
  logic [31:0]     sram_wdata, sram_rdata;
  logic [3:0]      sram_be;
  logic            kstart, kdone;
  logic [1599:0]   kdin, kdout;

  logic [31:0]     mem     [NW];
  logic [31:0]     ref_mem [NW];
  int              checks = 0;
  int              errors = 0;

  always #5 clk = ~clk;

  keccak_sram_sequencer_if #(.AddrWidth(AW)) bus ();

  keccak_sram_sequencer #(.NumWords(NW), .AddrWidth(AW), .BaseAddr(BASE)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
    .bus(bus),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata),
    .keccak_start_o(kstart), .keccak_din_o(kdin), .keccak_dout_i(kdout),
    .keccak_done_i(kdone)
  );

  // Behavioural SRAM with byte enables and one-cycle read latency
  always @(posedge clk) begin
    if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d; bus.be = be;
    #1;
    check1("wr_gnt", bus.gnt, 1'b1);
    tick();
    bus.req = 1'b0; bus.we = 1'b0;
    #1;
    check1("wr_no_rvalid", bus.rvalid, 1'b0);
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic bus_read(input logic [AW-1:0] a);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = a;
    #1;
    check1("rd_gnt", bus.gnt, 1'b1);
    tick();
    bus.req = 1'b0;
    #1;
    check1("rd_rvalid", bus.rvalid, 1'b1);
    check32("rd_data", bus.rdata, ref_mem[a]);
  endtask

  task automatic readback_all();
    for (int a = 0; a < NW; a++) bus_read(AW'(a));
  endtask

  // One permutation flow; cycle c counts from the IDLE cycle that has start=1
  task automatic run_flow(input int lat, input int abort_cnt, input bit stall, input bit simul);
    logic [31:0]   loaded [50];
    logic [1599:0] exp_din;
    int            d, k, bad;
    for (int i = 0; i < 50; i++) begin
      loaded[i]            = ref_mem[BASE+i];
      exp_din[32*i +: 32]  = ref_mem[BASE+i];
    end
    d = 53 + lat;
    start = 1'b1;
    if (simul) begin
      bus.req = 1'b1; bus.we = 1'b0; bus.addr = AW'(62);
    end
    #1;
    check1("c0_busy", busy, 1'b0);
    if (simul) check1("c0_gnt", bus.gnt, 1'b1);
    tick();
    start = 1'b0; bus.req = stall; bus.we = 1'b0; bus.addr = AW'(63);
    for (int c = 1; c <= d + 52; c++) begin
      kdone = (c == d) || (c == 10);
      if (c == d) kdout = ~exp_din;
      else for (int i = 0; i < 50; i++) kdout[32*i +: 32] = $urandom;
      start = (c == 53);
      if (abort_cnt >= 0 && c == d + 1 + abort_cnt) begin
        kdone = 1'b0; start = 1'b0; rst_n = 1'b0;
        #1;
        check1("ab_busy", busy, 1'b0);
        check1("ab_done", done, 1'b0);
        check1("ab_kstart", kstart, 1'b0);
        check1("ab_req", sram_req, 1'b0);
        check1("ab_we", sram_we, 1'b0);
        check32("ab_addr", 32'(sram_addr), 32'h0);
        check32("ab_wdata", sram_wdata, 32'h0);
        check32("ab_be", 32'(sram_be), 32'h0);
        check1("ab_rvalid", bus.rvalid, 1'b0);
        check1("ab_gnt", bus.gnt, 1'b0);
        checks++;
        assert (kdin === '0) else begin
          errors++;
          $error("FAIL ab_din: observed nonzero state register expected all zero");
        end
        tick();
        rst_n = 1'b1;
        return;
      end
      #1;
      check1("busy", busy, c <= d + 51);
      check1("done", done, c == d + 51);
      check1("kstart", kstart, c == 52);
      check1("gnt", bus.gnt, stall && c == d + 52);
      check1("rvalid", bus.rvalid, simul && c == 1);
      if (simul && c == 1) check32("simul_rdata", bus.rdata, ref_mem[62]);
      if (c <= 50) begin
        check1("ld_req", sram_req, 1'b1);
        check1("ld_we", sram_we, 1'b0);
        check32("ld_addr", 32'(sram_addr), BASE + c - 1);
      end else if (c > d && c <= d + 50) begin
        k = c - d - 1;
        check1("st_req", sram_req, 1'b1);
        check1("st_we", sram_we, 1'b1);
        check32("st_addr", 32'(sram_addr), BASE + k);
        check32("st_wdata", sram_wdata, ~loaded[k]);
        check32("st_be", 32'(sram_be), 32'hF);
        ref_mem[BASE+k] = ~loaded[k];
      end else if (c <= d + 51) begin
        check1("quiet_req", sram_req, 1'b0);
      end
      if (c == 52) begin
        bad = -1;
        for (int i = 0; i < 50; i++)
          if (kdin[32*i +: 32] !== exp_din[32*i +: 32] && bad < 0) bad = i;
        checks++;
        assert (bad < 0) else begin
          errors++;
          $error("FAIL din_at_start: word %0d observed %h expected %h",
                 bad, kdin[32*bad +: 32], exp_din[32*bad +: 32]);
        end
      end
      tick();
    end
    kdone = 1'b0; start = 1'b0;
    if (stall) begin
      bus.req = 1'b0;
      #1;
      check1("stall_rvalid", bus.rvalid, 1'b1);
      check32("stall_rdata", bus.rdata, ref_mem[63]);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; kdone = 1'b0; kdout = '0;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = 32'h0; bus.be = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_gnt", bus.gnt, 1'b0);
    check1("rst_rvalid", bus.rvalid, 1'b0);
    check32("rst_rdata", bus.rdata, 32'h0);
    check1("rst_req", sram_req, 1'b0);
    check1("rst_kstart", kstart, 1'b0);
    checks++;
    assert (kdin === '0) else begin
      errors++;
      $error("FAIL rst_din: observed nonzero state register expected all zero");
    end
    rst_n = 1'b1;
    tick();

    // Bus access: state words plus randomized partial writes elsewhere
    for (int k = 0; k < 50; k++) bus_write(AW'(BASE + k), 32'hA5A5_0000 + 32'(k), 4'hF);
    for (int a = 0; a < NW; a++) begin
      if (a < BASE || a >= BASE + 50) begin
        bus_write(AW'(a), $urandom, 4'hF);
        bus_write(AW'(a), $urandom, 4'($urandom_range(0, 15)));
      end
    end
    readback_all();

    // Full flow with core latency 24, start/read collision and stalled bus read
    for (int k = 0; k < 50; k++) bus_write(AW'(BASE + k), 32'(k), 4'hF);
    run_flow(24, -1, 1'b1, 1'b1);
    readback_all();

    // Random state, core done in the first RUN cycle
    for (int k = 0; k < 50; k++) bus_write(AW'(BASE + k), $urandom, 4'($urandom_range(1, 15)));
    run_flow(0, -1, 1'b0, 1'b0);
    readback_all();

    // Reset abort at STORE word 20
    for (int k = 0; k < 50; k++) bus_write(AW'(BASE + k), $urandom, 4'hF);
    run_flow(int'($urandom_range(1, 20)), 20, 1'b0, 1'b0);
    readback_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
